// File: rtl/ecg_pkg.sv
// Shared types and constants for the ECG rate chain.
package ecg_pkg;

  localparam int IDX_W_DEF = 11;
  localparam int DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    NO_REF = 2'd0,
    ARMED  = 2'd1,
    DIV    = 2'd2
  } state_e;

  function automatic int hr_num(input int fs);
    return 60 * fs;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W:0]    rem_sh;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;

  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    rem_d  = rem_sh[W-1:0];
    quo_d  = {quo_q[W-2:0], 1'b0};
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_d    = W'(rem_sh - {1'b0, dvs_q});
      quo_d[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= CW'(W);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q - 1'b1;
      done_q <= (cnt_q == CW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/rr_interval_hr.sv
// RR interval extraction, refractory rejection, averaging
// and BPM computation for accepted R peaks.
module rr_interval_hr
  import ecg_pkg::*;
#(
  parameter int FS      = 360,
  parameter int REFRACT = 72,
  parameter int AVG_N   = 8,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int DIV_W   = DIV_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    peak_valid,
  input  logic [IDX_W-1:0]        peak_index,
  input  logic signed [31:0]      peak_val,
  output logic                    rr_valid,
  output logic [IDX_W-1:0]        rr_interval,
  output logic [IDX_W-1:0]        avg_rr,
  output logic                    irregular,
  output logic                    hr_valid,
  output logic [7:0]              hr_bpm,
  output logic                    busy,
  output logic [7:0]              reject_cnt
);

  localparam int AW = clog2(AVG_N);
  localparam int SW = IDX_W + AW;
  localparam logic [DIV_W-1:0] HR_NUM = DIV_W'(hr_num(FS));

  state_e state_q, state_d;

  logic [IDX_W-1:0]   last_idx_q, last_idx_d;
  logic signed [31:0] last_val_q, last_val_d;
  logic [IDX_W-1:0]   rb_q [AVG_N];
  logic [AW-1:0]      ptr_q, ptr_d;
  logic [AW:0]        fill_q, fill_d;
  logic [SW-1:0]      sum_q, sum_d;

  logic             rr_valid_q, rr_valid_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] avg_q, avg_d;
  logic             irr_q, irr_d;
  logic             hr_valid_q, hr_valid_d;
  logic [7:0]       hr_q, hr_d;
  logic [7:0]       rej_q, rej_d;

  logic [IDX_W-1:0] rr, diff, evicted;
  logic             too_close, acc, full, push;
  logic             div_done;
  logic [DIV_W-1:0] quo;

  always_comb begin
    rr        = peak_index - last_idx_q;
    evicted   = rb_q[ptr_q];
    too_close = (rr < IDX_W'(REFRACT));
    acc       = peak_valid && (state_q != NO_REF) && !too_close;
    full      = (fill_q == (AW+1)'(AVG_N));
    diff      = (rr >= avg_q) ? rr - avg_q : avg_q - rr;

    state_d    = state_q;
    last_idx_d = last_idx_q;
    last_val_d = last_val_q;
    ptr_d      = ptr_q;
    fill_d     = fill_q;
    sum_d      = sum_q;
    rr_valid_d = 1'b0;
    rr_d       = rr_q;
    avg_d      = avg_q;
    irr_d      = irr_q;
    hr_valid_d = 1'b0;
    hr_d       = hr_q;
    rej_d      = rej_q;
    push       = 1'b0;

    unique case (state_q)
      NO_REF: begin
        if (peak_valid) begin
          last_idx_d = peak_index;
          last_val_d = peak_val;
          state_d    = ARMED;
        end
      end
      ARMED, DIV: begin
        if (state_q == DIV && div_done && !acc) begin
          hr_valid_d = 1'b1;
          hr_d       = (|quo[DIV_W-1:8]) ? 8'hff : quo[7:0];
          state_d    = ARMED;
        end
        if (peak_valid && too_close) begin
          if (rej_q != 8'hff) rej_d = rej_q + 8'd1;
          // A taller peak inside the window is the better R estimate
          if (peak_val > last_val_q) begin
            last_idx_d = peak_index;
            last_val_d = peak_val;
          end
        end
        if (acc) begin
          push       = 1'b1;
          rr_valid_d = 1'b1;
          rr_d       = rr;
          irr_d      = full && (diff > (avg_q >> 2));
          sum_d      = sum_q + SW'(rr) - SW'(evicted);
          fill_d     = full ? fill_q : fill_q + 1'b1;
          ptr_d      = ptr_q + 1'b1;
          avg_d      = (fill_d == (AW+1)'(AVG_N)) ?
                       IDX_W'(sum_d >> AW) : rr;
          last_idx_d = peak_index;
          last_val_d = peak_val;
          state_d    = DIV;
        end
      end
      default: state_d = NO_REF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= NO_REF;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx_q <= '0;
      last_val_q <= '0;
      ptr_q      <= '0;
      fill_q     <= '0;
      sum_q      <= '0;
      rr_valid_q <= 1'b0;
      rr_q       <= '0;
      avg_q      <= '0;
      irr_q      <= 1'b0;
      hr_valid_q <= 1'b0;
      hr_q       <= '0;
      rej_q      <= '0;
      for (int i = 0; i < AVG_N; i++) rb_q[i] <= '0;
    end else begin
      last_idx_q <= last_idx_d;
      last_val_q <= last_val_d;
      ptr_q      <= ptr_d;
      fill_q     <= fill_d;
      sum_q      <= sum_d;
      rr_valid_q <= rr_valid_d;
      rr_q       <= rr_d;
      avg_q      <= avg_d;
      irr_q      <= irr_d;
      hr_valid_q <= hr_valid_d;
      hr_q       <= hr_d;
      rej_q      <= rej_d;
      if (push) rb_q[ptr_q] <= rr;
    end
  end

  // Divide starts the cycle the new average is visible
  seq_divider #(.W(DIV_W)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (rr_valid_q),
    .dividend_i (HR_NUM),
    .divisor_i  (DIV_W'(avg_q)),
    .done_o     (div_done),
    .quotient_o (quo)
  );

  assign rr_valid    = rr_valid_q;
  assign rr_interval = rr_q;
  assign avg_rr      = avg_q;
  assign irregular   = irr_q;
  assign hr_valid    = hr_valid_q;
  assign hr_bpm      = hr_q;
  assign busy        = (state_q == DIV);
  assign reject_cnt  = rej_q;

endmodule

// File: tb/tb_rr_interval_hr.sv
// Bench for rr_interval_hr: beat-level reference model plus
// directed scenarios and randomized peak trains.
module tb_rr_interval_hr;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               peak_valid = 1'b0;
  logic [10:0]        peak_index = '0;
  logic signed [31:0] peak_val = '0;
  logic               rr_valid, irregular, hr_valid, busy;
  logic [10:0]        rr_interval, avg_rr;
  logic [7:0]         hr_bpm, reject_cnt;

  always #5 clk = ~clk;

  rr_interval_hr dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .peak_valid  (peak_valid),
    .peak_index  (peak_index),
    .peak_val    (peak_val),
    .rr_valid    (rr_valid),
    .rr_interval (rr_interval),
    .avg_rr      (avg_rr),
    .irregular   (irregular),
    .hr_valid    (hr_valid),
    .hr_bpm      (hr_bpm),
    .busy        (busy),
    .reject_cnt  (reject_cnt)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one entry per edge, expressed per beat
  int                 cyc, hr_due, busy_until, acc_cyc;
  bit                 have_ref;
  int                 m_last;
  logic signed [31:0] m_lastval;
  int                 ring[$];
  int                 e_rr, e_avg, e_hr, e_rej;
  bit                 e_rrv, e_hrv, e_irr, e_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; hr_due = -1; busy_until = -1; acc_cyc = -100;
      have_ref = 0; m_last = 0; m_lastval = 0;
      ring.delete();
      e_rr = 0; e_avg = 0; e_hr = 0; e_rej = 0;
      e_rrv = 0; e_hrv = 0; e_irr = 0; e_busy = 0;
    end else begin
      int rr, d, s;
      cyc++;
      e_rrv = 0;
      e_hrv = 0;
      if (cyc == hr_due) begin
        e_hrv = 1;
        e_hr  = (21600 / e_avg > 255) ? 255 : 21600 / e_avg;
      end
      if (peak_valid) begin
        if (!have_ref) begin
          have_ref = 1;
          m_last = int'(peak_index);
          m_lastval = peak_val;
        end else begin
          rr = (int'(peak_index) - m_last + 2048) % 2048;
          if (rr < 72) begin
            if (e_rej < 255) e_rej++;
            if (peak_val > m_lastval) begin
              m_last = int'(peak_index);
              m_lastval = peak_val;
            end
          end else begin
            d = rr - e_avg;
            if (d < 0) d = -d;
            e_irr = (ring.size() == 8) && (d > e_avg / 4);
            ring.push_back(rr);
            if (ring.size() > 8) void'(ring.pop_front());
            s = 0;
            foreach (ring[i]) s += ring[i];
            e_avg = (ring.size() == 8) ? s / 8 : rr;
            e_rrv = 1;
            e_rr = rr;
            m_last = int'(peak_index);
            m_lastval = peak_val;
            hr_due = cyc + 18;
            busy_until = cyc + 17;
            acc_cyc = cyc;
          end
        end
      end
      e_busy = (cyc <= busy_until);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_rr_valid", rr_valid, e_rrv);
      chk("m_rr_interval", rr_interval, e_rr);
      chk("m_avg_rr", avg_rr, e_avg);
      chk("m_hr_valid", hr_valid, e_hrv);
      chk("m_hr_bpm", hr_bpm, e_hr);
      chk("m_busy", busy, e_busy);
      chk("m_reject_cnt", reject_cnt, e_rej);
      if (e_rrv) chk("m_irregular", irregular, e_irr);
    end
  end

  task automatic pulse(input int idx, input int val);
    @(posedge clk);
    #1;
    peak_valid = 1'b1;
    peak_index = 11'(idx);
    peak_val   = val;
    @(posedge clk);
    #1;
    peak_valid = 1'b0;
  endtask

  task automatic beat(input int idx, input int val,
                      output int rr, output int avg,
                      output int irr, output int hr,
                      output int lat);
    rr = -1; avg = -1; irr = -1; hr = -1; lat = -1;
    pulse(idx, val);
    for (int n = 0; n < 30 && lat < 0; n++) begin
      @(negedge clk);
      if (rr_valid && rr < 0) begin
        rr  = int'(rr_interval);
        avg = int'(avg_rr);
        irr = int'(irregular);
      end
      if (hr_valid) begin
        hr  = int'(hr_bpm);
        lat = n;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rr, avg, irr, hr, lat, idx, cnt, kind, delta, gap;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rr_valid", rr_valid, 0);
    chk("rst_avg_rr", avg_rr, 0);
    chk("rst_hr_bpm", hr_bpm, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reject_cnt", reject_cnt, 0);
    rst_n = 1'b1;

    pulse(100, 50);
    repeat (2) @(negedge clk);
    beat(460, 50, rr, avg, irr, hr, lat);
    chk("t1_rr", rr, 360);
    chk("t1_avg", avg, 360);
    chk("t1_irr", irr, 0);
    chk("t1_hr", hr, 60);
    chk("t1_latency", lat, 18);

    pulse(500, 80);
    @(negedge clk);
    chk("t2_reject_cnt", reject_cnt, 1);
    chk("t2_no_rr", rr_valid, 0);
    beat(860, 10, rr, avg, irr, hr, lat);
    chk("t2_rr", rr, 360);

    beat(2000, 10, rr, avg, irr, hr, lat);
    chk("t3_pre_rr", rr, 1140);
    chk("t3_pre_hr", hr, 18);
    beat(312, 10, rr, avg, irr, hr, lat);
    chk("t3_wrap_rr", rr, 360);
    chk("t3_wrap_hr", hr, 60);

    idx = 312;
    for (int i = 0; i < 8; i++) begin
      idx = (idx + 300) % 2048;
      beat(idx, 10, rr, avg, irr, hr, lat);
    end
    chk("t4_avg", avg, 300);
    chk("t4_hr", hr, 72);
    idx = (idx + 400) % 2048;
    beat(idx, 10, rr, avg, irr, hr, lat);
    chk("t4_irr", irr, 1);
    chk("t4_avg2", avg, 312);
    chk("t4_hr2", hr, 69);

    pulse((idx + 360) % 2048, 10);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rr_valid", rr_valid, 0);
    chk("t6_rr_interval", rr_interval, 0);
    chk("t6_avg", avg_rr, 0);
    chk("t6_hr_bpm", hr_bpm, 0);
    chk("t6_busy0", busy, 0);
    chk("t6_reject_cnt", reject_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (hr_valid) cnt++;
    end
    chk("t6_no_hr", cnt, 0);
    pulse(10, 5);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rr_valid) cnt++;
    end
    chk("t6_noref", cnt, 0);

    pulse(81, 1);
    @(negedge clk);
    chk("t5_rej71", reject_cnt, 1);
    beat(82, 1, rr, avg, irr, hr, lat);
    chk("t5_rr", rr, 72);
    chk("t5_avg", avg, 72);
    chk("t5_hr_sat", hr, 255);
    chk("t5_latency", lat, 18);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 4);
      if (kind == 0) begin
        delta = $urandom_range(0, 71);
        gap = $urandom_range(0, 6);
      end else begin
        while (cyc < acc_cyc + 20) @(posedge clk);
        delta = $urandom_range(72, 1500);
        gap = $urandom_range(0, 30);
      end
      pulse(m_last + delta, int'($urandom));
      repeat (gap) @(posedge clk);
    end
    repeat (25) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_interval_hr.md
Name: rr_interval_hr

Overview:
Downstream consumer of the R-peak detector. Takes one-cycle R-peak events (sample index and amplitude) and rejects peaks that fall inside a refractory window. It derives the RR interval, keeps a running average over the last AVG_N intervals, flags irregular beats, and computes heart rate in BPM with a sequential divider. Results feed the display/telemetry stage.

Parameters:
FS, 360, sample rate in Hz. Sets the numerator HR_NUM = 60*FS (21600).
REFRACT, 72, minimum accepted RR in samples (200 ms at 360 Hz). Must be >= DIV_W+4.
AVG_N, 8, length of the RR averaging window. Power of two.
IDX_W, 11, width of the sample index. Index wraps modulo 2^IDX_W.
DIV_W, 16, numerator/divider width. One quotient bit per cycle.

Ports:
clk  in  1  system clock; one sample per clock, as in the ECG chain
rst_n  in  1  asynchronous active-low reset
peak_valid  in  1  one-cycle pulse: R peak reported
peak_index  in  IDX_W  sample number of the R peak
peak_val  in  32  R-peak amplitude, two's complement
rr_valid  out  1  one-cycle pulse: new accepted RR interval
rr_interval  out  IDX_W  last accepted RR, in samples
avg_rr  out  IDX_W  current averaged RR, in samples
irregular  out  1  qualifies rr_valid: |rr-avg_prev| > avg_prev/4
hr_valid  out  1  one-cycle pulse: hr_bpm updated
hr_bpm  out  8  heart rate in BPM, saturated at 255
busy  out  1  divider running
reject_cnt  out  8  refractory-rejected peak count, saturating at 255

Behaviour:
- Reset (async assert, sync-style release): all outputs 0, ring buffer and sum 0, fill count 0, state NO_REF.
- FSM states: NO_REF, ARMED, DIV.
- NO_REF: on peak_valid, latch last_idx and last_val, then go to ARMED. No outputs.
- ARMED, on peak_valid:
  - rr = (peak_index - last_idx) mod 2^IDX_W.
  - rr == 0 or rr < REFRACT: reject. reject_cnt++. If peak_val > last_val (signed compare), replace last_idx and last_val; otherwise ignore. No rr_valid.
  - Otherwise accept.
- Accept:
  - Next cycle: rr_valid=1 and rr_interval=rr.
  - irregular is computed against the pre-update avg_rr, and only once fill == AVG_N; otherwise irregular=0.
  - Push rr into a ring buffer of depth AVG_N. sum += rr - evicted.
  - fill saturates at AVG_N.
  - avg_rr = sum >> log2(AVG_N) when full; rr itself while filling.
  - Latch last_idx and last_val, then go to DIV.
- DIV:
  - Restoring divide of HR_NUM by avg_rr, DIV_W cycles.
  - On completion: hr_bpm = min(quotient, 255), hr_valid pulses for 1 cycle, return to ARMED.
  - busy=1 throughout DIV.
  - Total latency from peak_valid to hr_valid: 1 + DIV_W + 1 = 18 cycles.
- peak_valid during DIV: the refractory check still runs and rejects are counted. By the REFRACT constraint an accept is impossible here; if one occurs anyway, the buffer updates, rr_valid fires, and the divider restarts with the new avg_rr (last wins).
- Width rules:
  - sum is IDX_W+log2(AVG_N) bits and never overflows.
  - Divisor avg_rr >= REFRACT > 0, so there is no divide-by-zero.
- Index wrap is handled purely by modular subtraction. RR > 2^IDX_W-1 aliases; this is acceptable because it corresponds to < 11 BPM.
- Reset mid-DIV aborts the divide with no hr_valid.

Decomposition:
- Package ecg_pkg holds:
  - FSM state enum.
  - HR_NUM computation and the IDX_W/DIV_W defaults.
  - clog2 of AVG_N.
- One sub-module: seq_divider. Start/done handshake, unsigned restoring, DIV_W-bit. Reusable for other rate computations in the chain.

Test Plan:
1. Peaks at 100 then 460 -> rr_valid with rr_interval=360, avg_rr=360, irregular=0; hr_valid 18 cycles after the second peak with hr_bpm=60.
2. After an accepted peak at 460, peak at 500 with higher val -> rejected, reject_cnt=1, last_idx becomes 500. Next peak at 860 -> rr_interval=360.
3. last_idx=2000, next peak at 312 -> rr_interval=360, hr_bpm=60 (wrap-around).
4. Nine peaks 300 samples apart -> after the 8th interval avg_rr=300, hr_bpm=72. Then a peak 400 samples later -> irregular=1 and avg_rr=312.
5. RR=72 (minimum) -> 21600/72=300 -> hr_bpm saturates to 255.
6. Assert rst_n low mid-DIV (busy=1) -> all outputs 0 immediately and no hr_valid. First peak after release produces no rr_valid (state NO_REF).
